// File: rtl/serial_add_pkg.sv
// Shared constants for the bit-serial adder: default operand width,
// FSM state encoding and counter sizing.
package serial_add_pkg;

    localparam int SA_DEF_WIDTH = 8;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    // Bit counter must index 0..w-1; never narrower than one bit.
    function automatic int sa_cnt_width(input int w);
        if (w <= 2) begin
            return 1;
        end else begin
            return $clog2(w);
        end
    endfunction

    localparam int SA_DEF_CNT_W = sa_cnt_width(SA_DEF_WIDTH);

endpackage

// File: rtl/serial_add_ctrl_half_adder.sv
// Dataflow half adder; two of these form the full-add cell of the
// bit-serial adder.
module serial_add_ctrl_half_adder (
    input  logic i_x,
    input  logic i_y,
    output logic o_s,
    output logic o_c
);

    assign o_s = i_x ^ i_y;
    assign o_c = i_x & i_y;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: computes a + b + cin LSB first, one bit
// per clock, through a single shared full-add cell.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = SA_DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = sa_cnt_width(WIDTH);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic [CNT_W-1:0] r_cnt;
    logic             r_carry;
    logic             r_cout;
    logic             r_busy;
    logic             r_done;

    logic w_s1;
    logic w_c1;
    logic w_sum_bit;
    logic w_c2;
    logic w_carry_nxt;
    logic w_last;

    // Full-add cell: half adder on the operand bits, then on the carry.
    serial_add_ctrl_half_adder u_ha_ab (
        .i_x (r_a[0]),
        .i_y (r_b[0]),
        .o_s (w_s1),
        .o_c (w_c1)
    );

    serial_add_ctrl_half_adder u_ha_carry (
        .i_x (w_s1),
        .i_y (r_carry),
        .o_s (w_sum_bit),
        .o_c (w_c2)
    );

    assign w_carry_nxt = w_c1 | w_c2;
    assign w_last      = (r_cnt == CNT_W'(WIDTH - 1));

    // Next-state decode; start is only honoured from IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = SHIFT;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            SHIFT: begin
                if (w_last) begin
                    w_state_nxt = DONE;
                end else begin
                    w_state_nxt = SHIFT;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register with busy/done registered from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != IDLE);
            r_done  <= (w_state_nxt == DONE);
        end
    end

    // Operand capture and per-bit shifting of operands, carry and counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= {WIDTH{1'b0}};
            r_b     <= {WIDTH{1'b0}};
            r_carry <= 1'b0;
            r_cnt   <= {CNT_W{1'b0}};
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= cin;
                        r_cnt   <= {CNT_W{1'b0}};
                    end
                end
                SHIFT: begin
                    r_a     <= {1'b0, r_a[WIDTH-1:1]};
                    r_b     <= {1'b0, r_b[WIDTH-1:1]};
                    r_carry <= w_carry_nxt;
                    // Hold at the final index rather than wrapping.
                    if (!w_last) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Result registers are written only from the datapath while shifting,
    // so they hold their final values through DONE and IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sum  <= {WIDTH{1'b0}};
            r_cout <= 1'b0;
        end else if (r_state == SHIFT) begin
            r_sum <= {w_sum_bit, r_sum[WIDTH-1:1]};
            if (w_last) begin
                r_cout <= w_carry_nxt;
            end
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign sum  = r_sum;
    assign cout = r_cout;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8) with a result
// scoreboard popped on every done pulse.
module tb_serial_add_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;

    int n_checks = 0;
    int n_fail   = 0;
    int n_done   = 0;
    logic [8:0] exp_q[$];

    serial_add_ctrl #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [8:0] model(input logic [7:0] ma, input logic [7:0] mb, input logic mc);
        return {1'b0, ma} + {1'b0, mb} + {8'd0, mc};
    endfunction

    // Scoreboard: every done pulse must match the oldest expected result.
    always @(negedge clk) begin
        if (done) begin
            logic [8:0] e;
            n_done++;
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("sum", {24'd0, sum}, {24'd0, e[7:0]});
                check("cout", {31'd0, cout}, {31'd0, e[8]});
            end
        end
    end

    // One operation; p1/p2 are cycles with an extra start pulse, chg is the
    // cycle where the operand inputs are disturbed (0 = none).
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                          input int p1, input int p2, input int chg);
        int done_cyc;
        int d0;
        logic [8:0] e;
        @(negedge clk);
        a = ta; b = tb; cin = tc; start = 1'b1;
        e = model(ta, tb, tc);
        exp_q.push_back(e);
        d0 = n_done;
        done_cyc = -1;
        for (int cyc = 1; cyc <= 14; cyc++) begin
            @(negedge clk);
            start = (cyc == p1) || (cyc == p2);
            if (cyc == chg) begin
                a = 8'hAA; b = 8'h55; cin = 1'b1;
            end
            if (done && done_cyc < 0) done_cyc = cyc;
        end
        start = 1'b0;
        check("latency", done_cyc, 32'd9);
        check("done_count", n_done - d0, 32'd1);
        check("busy_idle", {31'd0, busy}, 32'd0);
        check("sum_hold", {24'd0, sum}, {24'd0, e[7:0]});
        check("cout_hold", {31'd0, cout}, {31'd0, e[8]});
    endtask

    initial begin
        int d0;
        int t[$];
        rst = 1'b1; start = 1'b0; a = 8'h00; b = 8'h00; cin = 1'b0;
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_sum", {24'd0, sum}, 32'd0);
        check("rst_cout", {31'd0, cout}, 32'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        run_op(8'h0F, 8'h01, 1'b0, 0, 0, 0);
        run_op(8'hFF, 8'h01, 1'b0, 0, 0, 0);
        run_op(8'hFF, 8'hFF, 1'b1, 0, 0, 0);
        run_op(8'h00, 8'h00, 1'b0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            run_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                   1'($urandom_range(0, 1)), 0, 0, 0);
        end

        // Start pulses while SHIFT and DONE must be ignored.
        run_op(8'h0F, 8'h01, 1'b0, 3, 9, 0);
        // Operand changes after acceptance must not matter.
        run_op(8'h0F, 8'h01, 1'b0, 0, 0, 2);

        // Asynchronous reset in the middle of cycle 4 aborts the operation.
        @(negedge clk);
        a = 8'h0F; b = 8'h01; cin = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk); @(negedge clk); @(negedge clk);
        d0 = n_done;
        #2 rst = 1'b1;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_done", {31'd0, done}, 32'd0);
        check("arst_sum", {24'd0, sum}, 32'd0);
        check("arst_cout", {31'd0, cout}, 32'd0);
        for (int i = 0; i < 12; i++) @(negedge clk);
        rst = 1'b0;
        check("arst_no_done", n_done - d0, 32'd0);
        run_op(8'h03, 8'h04, 1'b0, 0, 0, 0);

        // start held for 30 cycles: three back-to-back operations.
        @(negedge clk);
        a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
        for (int i = 0; i < 3; i++) exp_q.push_back(model(8'h01, 8'h01, 1'b0));
        for (int cyc = 1; cyc <= 34; cyc++) begin
            @(negedge clk);
            if (cyc == 30) start = 1'b0;
            if (done) t.push_back(cyc);
        end
        check("b2b_count", t.size(), 32'd3);
        if (t.size() == 3) begin
            check("b2b_first", t[0], 32'd9);
            check("b2b_gap1", t[1] - t[0], 32'd10);
            check("b2b_gap2", t[2] - t[1], 32'd10);
        end
        check("queue_empty", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
